imem_loader: RTL and testbench

Sequential writer that fills the byte-wide, big-endian instruction memory from a 32-bit word stream before the core starts fetching. It accepts words over a valid/ready handshake and splits each into four byte writes at consecutive addresses, most significant byte first. It sits between the boot/debug host interface and the write port of the instruction memory. The core's fetch path reads the same storage as {mem[a], mem[a+1], mem[a+2], mem[a+3]}.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills the byte-wide, big-endian instruction memory from a
// 32-bit word stream. Each accepted word becomes four consecutive byte
// writes, most significant byte at the lowest address.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start; start with word_count = 0 goes to DONE
// WAIT_WORD | in_ready high, waiting for an in_valid handshake
// WRITE     | one byte write per cycle, four cycles per word
// DONE      | one-cycle done pulse, then back to IDLE
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [31:0]         shift_q, shift_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic                wrapped_q, wrapped_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, datapath updates and registered status outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    wrapped_d   = wrapped_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero-length start still counts as accepted, so it clears wrapped too.
          wrapped_d = 1'b0;
          if (word_count != '0) begin
            state_d     = WAIT_WORD;
            ptr_d       = base_addr;
            remaining_d = word_count;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_WORD: begin
        if (in_valid) begin
          shift_d    = in_data;
          byte_idx_d = 2'd0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        shift_d    = shift_q << 8;
        ptr_d      = ptr_q + ADDR_W'(1);
        byte_idx_d = byte_idx_q + 2'd1;
        if (ptr_q == '1) begin
          wrapped_d = 1'b1;
        end
        if (byte_idx_q == 2'd3) begin
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? DONE : WAIT_WORD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next-state decode so they
    // line up with the state register without a combinational output path.
    in_ready_d = (state_d == WAIT_WORD);
    mem_we_d   = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      wrapped_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      wrapped_q   <= wrapped_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = shift_q[31:24];
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed loads, hand-written reset and
// idle sequences, then randomized loads checked against a byte-list model.
module tb_imem_loader;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 11;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready, mem_we, busy, done, wrapped;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: records every byte write, done pulses and their cycle numbers.
  int         cyc = 0;
  logic [19:0] wr_q[$];
  logic [7:0] mem_seen [0:DEPTH-1];
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         last_we_cyc = -1;
  int         ready_viol = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      mem_seen[mem_addr] = mem_wdata;
      last_we_cyc = cyc;
      if (in_ready) ready_viol++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver actions happen just after the falling edge, after the monitor.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // One complete load; inj pulses a stray start after the first handshake.
  task automatic run_load(input logic [ADDR_W-1:0] b, input int n,
                          input logic [3:0][31:0] w, input logic [3:0][3:0] g,
                          input bit inj, input string tag);
    int bound;
    int dc0;
    int exp_addr;
    logic [7:0]  exp_data;
    logic [31:0] fetched;
    wr_q.delete();
    dc0 = done_cnt;
    ready_viol = 0;
    start = 1'b1;
    base_addr = b;
    word_count = CNT_W'(n);
    tick();
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    word_count = CNT_W'($urandom);
    chk({tag, " busy@t+1"}, busy, 1);
    chk({tag, " in_ready@t+1"}, in_ready, (n > 0));
    chk({tag, " done@t+1"}, done, (n == 0));
    chk({tag, " wrapped cleared"}, wrapped, 0);
    for (int i = 0; i < n; i++) begin
      repeat (int'(g[i])) tick();
      in_valid = 1'b1;
      in_data = w[i];
      bound = 0;
      while (!in_ready && bound < 50) begin
        tick();
        bound++;
      end
      if (bound >= 50) chk({tag, " in_ready timeout"}, 0, 1);
      tick();
      in_valid = 1'b0;
      in_data = $urandom;
      if (inj && i == 0) begin
        start = 1'b1;
        base_addr = 12'h555;
        word_count = CNT_W'(7);
        tick();
        start = 1'b0;
      end
    end
    bound = 0;
    while (done_cnt == dc0 && bound < 50) begin
      tick();
      bound++;
    end
    if (bound >= 50) chk({tag, " done timeout"}, 0, 1);
    if (n > 0) chk({tag, " done latency"}, done_cyc - last_we_cyc, 1);
    tick();
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle done"}, done, 0);
    chk({tag, " done pulses"}, done_cnt - dc0, 1);
    chk({tag, " in_ready in write"}, ready_viol, 0);
    chk({tag, " write count"}, wr_q.size(), 4 * n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_addr = (int'(b) + 4 * i + j) % DEPTH;
        exp_data = 8'(w[i] >> (24 - 8 * j));
        if (4 * i + j < wr_q.size())
          chk({tag, " byte"}, wr_q[4 * i + j], {ADDR_W'(exp_addr), exp_data});
      end
      exp_addr = (int'(b) + 4 * i) % DEPTH;
      fetched = {mem_seen[exp_addr], mem_seen[(exp_addr + 1) % DEPTH],
                 mem_seen[(exp_addr + 2) % DEPTH], mem_seen[(exp_addr + 3) % DEPTH]};
      chk({tag, " fetch word"}, fetched, w[i]);
    end
    chk({tag, " wrapped"}, wrapped, (int'(b) + 4 * n >= DEPTH));
  endtask

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [3:0]        n;
    logic [3:0][31:0]  w;
    logic [3:0][3:0]   gap;
    logic              inj;
    logic              exp_wrapped;
    logic [ADDR_W-1:0] exp_last_addr;
    logic [7:0]        exp_last_byte;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [ADDR_W-1:0] rb;
    int rn;
    logic [3:0][31:0] rw;
    logic [3:0][3:0]  rg;
    int dc0;
    int bound;

    vt[0] = '{base: 12'h010, n: 4'd1, w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
              gap: {4'd0, 4'd0, 4'd0, 4'd0}, inj: 1'b0, exp_wrapped: 1'b0,
              exp_last_addr: 12'h013, exp_last_byte: 8'hEF};
    vt[1] = '{base: 12'h020, n: 4'd3, w: {32'h0, 32'hCAFEF00D, 32'hA5A6A7A8, 32'h01020304},
              gap: {4'd0, 4'd7, 4'd2, 4'd0}, inj: 1'b0, exp_wrapped: 1'b0,
              exp_last_addr: 12'h02B, exp_last_byte: 8'h0D};
    vt[2] = '{base: 12'hFFE, n: 4'd1, w: {32'h0, 32'h0, 32'h0, 32'h11223344},
              gap: {4'd0, 4'd0, 4'd0, 4'd0}, inj: 1'b0, exp_wrapped: 1'b1,
              exp_last_addr: 12'h001, exp_last_byte: 8'h44};
    vt[3] = '{base: 12'h123, n: 4'd0, w: {32'h0, 32'h0, 32'h0, 32'h0},
              gap: {4'd0, 4'd0, 4'd0, 4'd0}, inj: 1'b0, exp_wrapped: 1'b0,
              exp_last_addr: 12'h000, exp_last_byte: 8'h00};
    vt[4] = '{base: 12'h200, n: 4'd2, w: {32'h0, 32'h0, 32'h76543210, 32'h89ABCDEF},
              gap: {4'd0, 4'd0, 4'd1, 4'd0}, inj: 1'b1, exp_wrapped: 1'b0,
              exp_last_addr: 12'h207, exp_last_byte: 8'h10};

    for (int a = 0; a < DEPTH; a++) mem_seen[a] = 8'h00;

    // Reset and idle behaviour.
    do_reset();
    chk("reset in_ready", in_ready, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wrapped", wrapped, 0);
    wr_q.delete();
    in_valid = 1'b1;
    in_data = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("idle no writes", wr_q.size(), 0);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      run_load(vt[v].base, int'(vt[v].n), vt[v].w, vt[v].gap, vt[v].inj, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d wrapped tbl", v), wrapped, vt[v].exp_wrapped);
      if (vt[v].n != 0 && wr_q.size() > 0)
        chk($sformatf("vec%0d last write", v), wr_q[wr_q.size() - 1],
            {vt[v].exp_last_addr, vt[v].exp_last_byte});
      if (vt[v].exp_wrapped) begin
        repeat (3) tick();
        chk($sformatf("vec%0d wrapped sticky", v), wrapped, 1);
      end
    end

    // Reset in the middle of a word, after its second byte.
    wr_q.delete();
    dc0 = done_cnt;
    start = 1'b1;
    base_addr = 12'h300;
    word_count = CNT_W'(1);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h13579BDF;
    tick();
    in_valid = 1'b0;
    bound = 0;
    while (wr_q.size() < 2 && bound < 20) begin
      tick();
      bound++;
    end
    chk("midreset bytes before", wr_q.size(), 2);
    reset = 1'b0;
    #1;
    chk("midreset mem_we", mem_we, 0);
    chk("midreset busy", busy, 0);
    chk("midreset in_ready", in_ready, 0);
    chk("midreset mem_addr", mem_addr, 0);
    chk("midreset mem_wdata", mem_wdata, 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("midreset no done", done_cnt - dc0, 0);
    chk("midreset no more writes", wr_q.size(), 2);
    run_load(12'h100, 1, {32'h0, 32'h0, 32'h0, 32'h0BADF00D}, '0, 1'b0, "after_reset");

    // Randomized loads against the byte-list model.
    for (int r = 0; r < 25; r++) begin
      rb = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) rb = ADDR_W'(12'hFF0 + $urandom_range(0, 15));
      rn = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        rw[i] = $urandom;
        rg[i] = 4'($urandom_range(0, 3));
      end
      run_load(rb, rn, rw, rg, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
